display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the microwave timer display. It shares one external bcd_seven decoder across NUM_DIGITS common-cathode digits. Each slot, it presents one digit's BCD code to the decoder and drives that digit's enable. It also handles leading-zero blanking, per-digit blinking, anti-ghosting gaps and tear-free updates at frame boundaries.

---
 rtl/display_pkg.sv | 13 +
 rtl/scan_tick.sv | 35 +++
 rtl/display_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed timer display: scan states and BCD code constants.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    localparam int           BCD_W     = 4;
    localparam logic [3:0]   BCD_BLANK = 4'hF;

endpackage

// File: rtl/scan_tick.sv
// Slot divider: counts cycles within a digit slot and flags the last gap cycle and last slot cycle.
module scan_tick #(
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_GAP   = 2,
    parameter int DIV_W       = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_run,
    output logic [DIV_W-1:0] o_div,
    output logic             o_slot_end,
    output logic             o_gap_end
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(BLANK_GAP - 1);

    logic [DIV_W-1:0] r_div;

    // Counter parks at zero whenever scanning is not running, so every slot starts aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (!i_run || (r_div == DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign o_div      = r_div;
    assign o_slot_end = i_run && (r_div == DIV_LAST);
    assign o_gap_end  = i_run && (r_div == GAP_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller sharing one BCD-to-seven-segment decoder across NUM_DIGITS digits,
// with leading-zero blanking, per-digit blink and frame-aligned (tear-free) data updates.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_GAP    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic                        load,
    input  logic                        lz_blank,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    output logic [BCD_W-1:0]            bcd_sel,
    output logic [NUM_DIGITS-1:0]       digit_en,
    output logic                        frame_done
);

    localparam int DW    = BCD_W * NUM_DIGITS;
    localparam int DIV_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int IDX_W = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
    localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_PRELAST = DIV_W'(REFRESH_DIV - 2);
    localparam logic [BC_W-1:0]  BLINK_LAST  = BC_W'(BLINK_FRAMES - 1);

    state_e                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DW-1:0]         r_pending;
    logic [DW-1:0]         r_shadow;
    logic                  r_pend_valid;
    logic                  r_blink_on;
    logic [BC_W-1:0]       r_blink_cnt;
    logic [BCD_W-1:0]      r_bcd_sel;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                  r_frame_done;

    logic                  w_run;
    logic [DIV_W-1:0]      w_div;
    logic                  w_slot_end;
    logic                  w_gap_end;
    logic                  w_frame_end;
    logic                  w_direct_load;
    state_e                w_state_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [DW-1:0]         w_shadow_nxt;
    logic                  w_blink_on_nxt;
    logic [BCD_W-1:0]      w_bcd_nxt;
    logic [NUM_DIGITS-1:0] w_digit_en_nxt;
    logic                  w_frame_done_nxt;

    function automatic logic [BCD_W-1:0] digit_of(input logic [DW-1:0] shadow,
                                                  input logic [IDX_W-1:0] idx);
        return shadow[BCD_W*int'(idx) +: BCD_W];
    endfunction

    // Codes 10-15 are nonzero here, so they stop leading-zero blanking like any digit.
    function automatic logic suppressed(input logic [DW-1:0]         shadow,
                                        input logic [IDX_W-1:0]      idx,
                                        input logic                  lz,
                                        input logic [NUM_DIGITS-1:0] mask,
                                        input logic                  blink_on);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(idx)) && (shadow[BCD_W*k +: BCD_W] != '0)) begin
                upper_zero = 1'b0;
            end
        end
        return (lz && (idx != '0) && upper_zero) || (!blink_on && mask[idx]);
    endfunction

    assign w_run = enable && (r_state != ST_IDLE);

    scan_tick #(
        .REFRESH_DIV(REFRESH_DIV),
        .BLANK_GAP  (BLANK_GAP),
        .DIV_W      (DIV_W)
    ) u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_run     (w_run),
        .o_div     (w_div),
        .o_slot_end(w_slot_end),
        .o_gap_end (w_gap_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_GAP;
                    w_idx_nxt   = '0;
                end
                ST_GAP: begin
                    if (w_gap_end) w_state_nxt = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (w_slot_end) begin
                        w_state_nxt = ST_GAP;
                        w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    assign w_frame_end    = enable && (r_state == ST_DRIVE) && w_slot_end && (r_idx == IDX_LAST);
    assign w_direct_load  = load && (w_frame_end || (r_state == ST_IDLE));
    assign w_shadow_nxt   = w_direct_load                 ? digits_in :
                            (w_frame_end && r_pend_valid) ? r_pending : r_shadow;
    assign w_blink_on_nxt = (w_frame_end && (r_blink_cnt == BLINK_LAST)) ? !r_blink_on : r_blink_on;

    // Outputs are computed for the state being entered so they register in step with it;
    // bcd_sel therefore changes on GAP entry, ahead of any enable.
    always_comb begin
        w_bcd_nxt        = '0;
        w_digit_en_nxt   = '0;
        w_frame_done_nxt = 1'b0;
        if (w_state_nxt != ST_IDLE) begin
            w_bcd_nxt = digit_of(w_shadow_nxt, w_idx_nxt);
        end
        if ((w_state_nxt == ST_DRIVE) &&
            !suppressed(w_shadow_nxt, w_idx_nxt, lz_blank, blink_mask, w_blink_on_nxt)) begin
            w_digit_en_nxt = NUM_DIGITS'(1) << w_idx_nxt;
        end
        if ((w_state_nxt == ST_DRIVE) && (w_idx_nxt == IDX_LAST) && (w_div == DIV_PRELAST)) begin
            w_frame_done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_pending    <= '0;
            r_shadow     <= '0;
            r_pend_valid <= 1'b0;
            r_blink_on   <= 1'b1;
            r_blink_cnt  <= '0;
            r_bcd_sel    <= '0;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_shadow     <= w_shadow_nxt;
            r_bcd_sel    <= w_bcd_nxt;
            r_digit_en   <= w_digit_en_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_blink_on   <= w_blink_on_nxt;
            if (load) r_pending <= digits_in;
            if (w_direct_load) begin
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend_valid <= 1'b1;
            end else if (w_frame_end) begin
                r_pend_valid <= 1'b0;
            end
            if (w_frame_end) begin
                r_blink_cnt <= (r_blink_cnt == BLINK_LAST) ? '0 : r_blink_cnt + BC_W'(1);
            end
        end
    end

    assign bcd_sel    = r_bcd_sel;
    assign digit_en   = r_digit_en;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random traffic against a time-based reference model.
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int BG = 1;
    localparam int BF = 2;
    localparam int FR = N * RD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] digits_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  bcd_sel;
    logic [3:0]  digit_en;
    logic        frame_done;

    display_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .BLANK_GAP   (BG),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .digits_in (digits_in),
        .load      (load),
        .lz_blank  (lz_blank),
        .blink_mask(blink_mask),
        .bcd_sel   (bcd_sel),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: scanning is a running cycle count since the first gap cycle; slot/position/frame follow by arithmetic.
    bit          m_run;
    int          m_t;
    logic [15:0] m_shadow;
    logic [15:0] m_pend;
    bit          m_pv;
    bit          m_on;
    int          m_bcnt;
    logic [3:0]  e_bcd;
    logic [3:0]  e_en;
    logic        e_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_t = 0; m_shadow = '0; m_pend = '0; m_pv = 0; m_on = 1; m_bcnt = 0;
    endfunction

    function automatic void model_expect();
        int          idx;
        int          pos;
        logic [15:0] upper;
        bit          sup;
        e_bcd = '0; e_en = '0; e_fd = 1'b0;
        if (m_run) begin
            idx   = (m_t / RD) % N;
            pos   = m_t % RD;
            upper = m_shadow >> (4 * idx);
            sup   = (lz_blank && idx != 0 && upper == 16'h0) || (!m_on && blink_mask[idx]);
            e_bcd = upper[3:0];
            e_en  = (pos >= BG && !sup) ? 4'(1 << idx) : 4'h0;
            e_fd  = ((m_t % FR) == FR - 1);
        end
    endfunction

    function automatic void model_edge();
        bit fend;
        bit was_idle;
        if (!reset_n) begin
            model_reset();
        end else begin
            fend     = enable && m_run && ((m_t % FR) == FR - 1);
            was_idle = !m_run;
            if (load && (fend || was_idle)) begin
                m_shadow = digits_in; m_pend = digits_in; m_pv = 0;
            end else begin
                if (fend && m_pv) begin m_shadow = m_pend; m_pv = 0; end
                if (load) begin m_pend = digits_in; m_pv = 1; end
            end
            if (fend) begin
                m_bcnt++;
                if (m_bcnt == BF) begin m_bcnt = 0; m_on = !m_on; end
            end
            if (!enable) m_run = 0;
            else if (was_idle) begin m_run = 1; m_t = 0; end
            else m_t++;
        end
        model_expect();
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("bcd_sel", 32'(bcd_sel), 32'(e_bcd));
        chk("digit_en", 32'(digit_en), 32'(e_en));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("onehot", 32'($countones(digit_en) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        digits_in = v; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        model_reset();
        model_expect();
        // Reset state
        run(2);
        chk("rst_en", 32'(digit_en), 32'h0);
        chk("rst_bcd", 32'(bcd_sel), 32'h0);
        reset_n = 1'b1;

        // Basic scan of 0x1234
        enable = 1'b1;
        do_load(16'h1234);
        tick();
        chk("first_en", 32'(digit_en), 32'h1);
        chk("first_bcd", 32'(bcd_sel), 32'h4);
        run(40);

        // Leading-zero blanking
        lz_blank = 1'b1;
        do_load(16'h0050);
        run(36);
        do_load(16'h0000);
        run(36);
        lz_blank = 1'b0;

        // Mid-frame load waits for the frame boundary
        for (int i = 0; i < 64; i++) begin
            if (m_run && (m_t % FR) == 4) break;
            tick();
        end
        chk("wait_mid", 32'(m_run && (m_t % FR) == 4), 32'd1);
        do_load(16'h9999);
        run(30);
        // Load coinciding with the frame-done cycle
        for (int i = 0; i < 64; i++) begin
            if (e_fd) break;
            tick();
        end
        chk("wait_fd", 32'(e_fd), 32'd1);
        do_load(16'h5678);
        chk("fd_load_bcd", 32'(bcd_sel), 32'h8);
        run(20);

        // Blink
        blink_mask = 4'b0011;
        run(6 * FR);
        blink_mask = 4'b0000;

        // Disable during digit 2 drive, then re-enable
        for (int i = 0; i < 64; i++) begin
            if (m_run && ((m_t / RD) % N) == 2 && (m_t % RD) >= BG) break;
            tick();
        end
        chk("wait_d2", 32'(m_run && ((m_t / RD) % N) == 2), 32'd1);
        enable = 1'b0;
        tick();
        chk("dis_en", 32'(digit_en), 32'h0);
        run(3);
        enable = 1'b1;
        run(20);

        // Asynchronous reset mid-slot
        for (int i = 0; i < 64; i++) begin
            if (m_run && (m_t % RD) == 2) break;
            tick();
        end
        chk("wait_mid_slot", 32'(m_run && (m_t % RD) == 2), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_en", 32'(digit_en), 32'h0);
        chk("arst_bcd", 32'(bcd_sel), 32'h0);
        chk("arst_fd", 32'(frame_done), 32'h0);
        model_reset();
        model_expect();
        tick();
        reset_n = 1'b1;

        // Code 0xA counts as nonzero for blanking
        lz_blank = 1'b1;
        do_load(16'h00A0);
        run(40);

        // Random traffic
        for (int i = 0; i < 900; i++) begin
            enable    = ($urandom_range(0, 99) < 96);
            load      = ($urandom_range(0, 11) == 0);
            digits_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) digits_in[15:8] = 8'h00;
            if ((i % 64) == 0) lz_blank = 1'($urandom);
            if ((i % 50) == 0) blink_mask = 4'($urandom);
            tick();
        end
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
